// File: rtl/inst_mem_loader_if.sv
// Host-side byte stream, instruction-memory write port and CPU control signals
// for the instruction-memory loader.
interface inst_mem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic [15:0]       checksum;

  // Master drives the load request and byte stream; slave is the loader.
  modport master (
    output start, word_count, in_byte, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, checksum
  );

  modport slave (
    input  start, word_count, in_byte, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, checksum
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Serial-to-word instruction-memory loader: assembles big-endian 32-bit words
// from a byte stream, writes them in order and holds the CPU until loaded.
module inst_mem_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clock,
  input  logic              reset_n,
  inst_mem_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [15:0]       checksum_q, checksum_d;
  logic              loaded_q, loaded_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              accept;
  logic [ADDR_W:0]   clamped_count;
  logic [ADDR_W:0]   word_idx_inc;
  logic [31:0]       assembled;

  assign accept        = (state_q == S_RECV) && bus.in_valid;
  assign clamped_count = (bus.word_count > DEPTH_C) ? DEPTH_C : bus.word_count;
  assign word_idx_inc  = word_idx_q + 1'b1;

  // Bytes 0..2 of the current word are parked in lane registers; byte 3 goes
  // straight from the input into the assembled word.
  for (genvar gi = 0; gi < 3; gi++) begin : lane_g
    logic [7:0] lane_q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        lane_q <= 8'h00;
      end else if (accept && (byte_idx_q == 2'(gi))) begin
        lane_q <= bus.in_byte;
      end
    end
  end

  assign assembled = {lane_g[0].lane_q, lane_g[1].lane_q, lane_g[2].lane_q, bus.in_byte};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= 2'd0;
      checksum_q <= 16'h0000;
      loaded_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      checksum_q <= checksum_d;
      loaded_q   <= loaded_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    checksum_d   = checksum_q;
    loaded_d     = loaded_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    bus.in_ready = 1'b0;
    bus.mem_we   = 1'b0;
    bus.cpu_hold = 1'b1;
    bus.done     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // The CPU runs freely only once a load has completed since reset.
        bus.cpu_hold = ~loaded_q;
        if (bus.start) begin
          count_d    = clamped_count;
          word_idx_d = '0;
          byte_idx_d = 2'd0;
          checksum_d = 16'h0000;
          state_d    = (clamped_count == '0) ? S_DONE : S_RECV;
        end
      end

      S_RECV: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          checksum_d = checksum_q + {8'h00, bus.in_byte};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            addr_d  = word_idx_q[ADDR_W-1:0];
            wdata_d = assembled;
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        bus.mem_we = 1'b1;
        word_idx_d = word_idx_inc;
        state_d    = (word_idx_inc == count_q) ? S_DONE : S_RECV;
      end

      S_DONE: begin
        bus.cpu_hold = 1'b0;
        bus.done     = 1'b1;
        loaded_d     = 1'b1;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Address and data are registered so they hold between write strobes.
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.checksum  = checksum_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: cycle-exact table for a 2-word load plus
// sequences for gapped input, zero count, clamping and reset mid-load.
module tb_inst_mem_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  typedef struct packed {
    logic        st;
    logic [10:0] wc;
    logic [7:0]  b;
    logic        v;
    logic        r;
    logic        we;
    logic [9:0]  a;
    logic [31:0] d;
    logic        h;
    logic        dn;
    logic [15:0] cs;
  } vec_t;

  logic clock;
  logic reset_n;

  inst_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  inst_mem_loader #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [9:0]  wq_addr[$];
  logic [31:0] wq_data[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Write/done monitor; the loader must never offer in_ready while writing.
  always @(negedge clock) begin
    if (reset_n && bus.mem_we) begin
      wq_addr.push_back(bus.mem_addr);
      wq_data.push_back(bus.mem_wdata);
      check("ready_during_write", 32'(bus.in_ready), 32'd0);
    end
    if (reset_n && bus.done) done_cnt++;
  end

  task automatic pulse_start(input logic [10:0] wc);
    bus.start      = 1'b1;
    bus.word_count = wc;
    @(posedge clock); #1;
    bus.start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      @(posedge clock); #1;
    end
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    guard = 0;
    @(negedge clock);
    while (!bus.in_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (!bus.in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL byte_accept_timeout: in_ready %b, expected 1", bus.in_ready);
    end
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!bus.done && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    if (!bus.done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_done_timeout: done %b, expected 1", name, bus.done);
    end
    @(posedge clock); #1;
  endtask

  function automatic logic [7:0] clamp_byte(input int w, input int k);
    logic [15:0] wv;
    wv = 16'(w);
    case (k)
      0:       return wv[15:8];
      1:       return wv[7:0];
      2:       return 8'hC3;
      default: return wv[7:0] ^ 8'h5A;
    endcase
  endfunction

  vec_t        vec [13];
  logic [7:0]  stream [8];
  logic [15:0] exp_cs;
  int          d0, wn, bad;

  initial begin
    stream = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h08, 8'h00, 8'h00, 8'h03};
    //            st    wc      b      v     r     we    a       d              h     dn    cs
    vec[0]  = '{1'b1, 11'd2, 8'h00, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0000_0000, 1'b1, 1'b0, 16'h0000};
    vec[1]  = '{1'b0, 11'd0, 8'h8C, 1'b1, 1'b1, 1'b0, 10'd0, 32'h0000_0000, 1'b1, 1'b0, 16'h0000};
    vec[2]  = '{1'b0, 11'd0, 8'h01, 1'b1, 1'b1, 1'b0, 10'd0, 32'h0000_0000, 1'b1, 1'b0, 16'h008C};
    vec[3]  = '{1'b0, 11'd0, 8'h00, 1'b1, 1'b1, 1'b0, 10'd0, 32'h0000_0000, 1'b1, 1'b0, 16'h008D};
    vec[4]  = '{1'b0, 11'd0, 8'h04, 1'b1, 1'b1, 1'b0, 10'd0, 32'h0000_0000, 1'b1, 1'b0, 16'h008D};
    vec[5]  = '{1'b0, 11'd0, 8'h08, 1'b1, 1'b0, 1'b1, 10'd0, 32'h8C01_0004, 1'b1, 1'b0, 16'h0091};
    vec[6]  = '{1'b0, 11'd0, 8'h08, 1'b1, 1'b1, 1'b0, 10'd0, 32'h8C01_0004, 1'b1, 1'b0, 16'h0091};
    vec[7]  = '{1'b1, 11'd0, 8'h00, 1'b1, 1'b1, 1'b0, 10'd0, 32'h8C01_0004, 1'b1, 1'b0, 16'h0099};
    vec[8]  = '{1'b0, 11'd0, 8'h00, 1'b1, 1'b1, 1'b0, 10'd0, 32'h8C01_0004, 1'b1, 1'b0, 16'h0099};
    vec[9]  = '{1'b0, 11'd0, 8'h03, 1'b1, 1'b1, 1'b0, 10'd0, 32'h8C01_0004, 1'b1, 1'b0, 16'h0099};
    vec[10] = '{1'b0, 11'd0, 8'h00, 1'b0, 1'b0, 1'b1, 10'd1, 32'h0800_0003, 1'b1, 1'b0, 16'h009C};
    vec[11] = '{1'b1, 11'd3, 8'h00, 1'b0, 1'b0, 1'b0, 10'd1, 32'h0800_0003, 1'b0, 1'b1, 16'h009C};
    vec[12] = '{1'b0, 11'd0, 8'h00, 1'b0, 1'b0, 1'b0, 10'd1, 32'h0800_0003, 1'b0, 1'b0, 16'h009C};

    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.word_count = '0;
    bus.in_byte    = 8'h00;
    bus.in_valid   = 1'b0;
    #12;
    check("rst.in_ready", 32'(bus.in_ready), 32'd0);
    check("rst.mem_we",   32'(bus.mem_we),   32'd0);
    check("rst.cpu_hold", 32'(bus.cpu_hold), 32'd1);
    check("rst.done",     32'(bus.done),     32'd0);
    check("rst.checksum", 32'(bus.checksum), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Two-word load, cycle by cycle (busy starts in RECV and DONE are ignored).
    for (int i = 0; i < 13; i++) begin
      bus.start      = vec[i].st;
      bus.word_count = vec[i].wc;
      bus.in_byte    = vec[i].b;
      bus.in_valid   = vec[i].v;
      @(negedge clock);
      check($sformatf("t1[%0d].in_ready", i),  32'(bus.in_ready),  32'(vec[i].r));
      check($sformatf("t1[%0d].mem_we", i),    32'(bus.mem_we),    32'(vec[i].we));
      check($sformatf("t1[%0d].mem_addr", i),  32'(bus.mem_addr),  32'(vec[i].a));
      check($sformatf("t1[%0d].mem_wdata", i), bus.mem_wdata,      vec[i].d);
      check($sformatf("t1[%0d].cpu_hold", i),  32'(bus.cpu_hold),  32'(vec[i].h));
      check($sformatf("t1[%0d].done", i),      32'(bus.done),      32'(vec[i].dn));
      check($sformatf("t1[%0d].checksum", i),  32'(bus.checksum),  32'(vec[i].cs));
      @(posedge clock); #1;
    end
    bus.start = 1'b0;
    check("t1.done_count", 32'(done_cnt), 32'd1);

    // Gapped stream: same result, checksum cleared by the new start.
    wq_addr.delete();
    wq_data.delete();
    d0 = done_cnt;
    pulse_start(11'd2);
    @(negedge clock);
    check("t2.cs_cleared", 32'(bus.checksum), 32'd0);
    check("t2.hold_up",    32'(bus.cpu_hold), 32'd1);
    @(posedge clock); #1;
    for (int i = 0; i < 8; i++) send_byte(stream[i], 1);
    wait_done("t2");
    check("t2.writes",   32'(wq_addr.size()), 32'd2);
    if (wq_addr.size() == 2) begin
      check("t2.addr0", 32'(wq_addr[0]), 32'd0);
      check("t2.data0", wq_data[0], 32'h8C01_0004);
      check("t2.addr1", 32'(wq_addr[1]), 32'd1);
      check("t2.data1", wq_data[1], 32'h0800_0003);
    end
    check("t2.checksum", 32'(bus.checksum), 32'h009C);
    check("t2.done_once", 32'(done_cnt - d0), 32'd1);
    @(negedge clock);
    check("t2.hold_after", 32'(bus.cpu_hold), 32'd0);
    @(posedge clock); #1;

    // Zero count: straight to DONE, no writes.
    wq_addr.delete();
    d0 = done_cnt;
    pulse_start(11'd0);
    @(negedge clock);
    check("t3.done",     32'(bus.done),     32'd1);
    check("t3.hold",     32'(bus.cpu_hold), 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check("t3.done_end", 32'(bus.done),     32'd0);
    check("t3.hold_end", 32'(bus.cpu_hold), 32'd0);
    check("t3.no_write", 32'(wq_addr.size()), 32'd0);
    check("t3.done_once", 32'(done_cnt - d0), 32'd1);
    @(posedge clock); #1;

    // Count 2047 clamps to 1024 words; start pulses mid-load are ignored.
    wq_addr.delete();
    wq_data.delete();
    d0 = done_cnt;
    exp_cs = 16'h0000;
    pulse_start(11'd2047);
    for (int w = 0; w < DEPTH; w++) begin
      for (int k = 0; k < 4; k++) begin
        if ((w == 2 && k == 1) || (w == 500 && k == 3)) begin
          bus.start      = 1'b1;
          bus.word_count = 11'd3;
        end
        exp_cs = exp_cs + 16'(clamp_byte(w, k));
        send_byte(clamp_byte(w, k), 0);
        bus.start = 1'b0;
      end
    end
    wait_done("t4");
    check("t4.writes", 32'(wq_addr.size()), 32'(DEPTH));
    bad = 0;
    wn = (wq_addr.size() < DEPTH) ? wq_addr.size() : DEPTH;
    for (int w = 0; w < wn; w++) begin
      if (wq_addr[w] !== 10'(w) ||
          wq_data[w] !== {clamp_byte(w, 0), clamp_byte(w, 1), clamp_byte(w, 2), clamp_byte(w, 3)})
        bad++;
    end
    check("t4.order_bad_count", 32'(bad), 32'd0);
    check("t4.checksum",  32'(bus.checksum), 32'(exp_cs));
    check("t4.done_once", 32'(done_cnt - d0), 32'd1);

    // Reset after byte 6 of an 8-byte load.
    wq_addr.delete();
    wq_data.delete();
    d0 = done_cnt;
    pulse_start(11'd2);
    for (int i = 0; i < 6; i++) send_byte(stream[i], 0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("t5.rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("t5.rst_mem_we",    32'(bus.mem_we),    32'd0);
    check("t5.rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("t5.rst_mem_wdata", bus.mem_wdata,      32'd0);
    check("t5.rst_cpu_hold",  32'(bus.cpu_hold),  32'd1);
    check("t5.rst_checksum",  32'(bus.checksum),  32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    repeat (4) begin
      bus.in_byte  = 8'hEE;
      bus.in_valid = 1'b1;
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;
    check("t5.no_write_after", 32'(wq_addr.size()), 32'd1);
    check("t5.no_done",        32'(done_cnt - d0),  32'd0);
    @(negedge clock);
    check("t5.idle_hold", 32'(bus.cpu_hold), 32'd1);
    @(posedge clock); #1;
    wq_addr.delete();
    wq_data.delete();
    pulse_start(11'd1);
    @(negedge clock);
    check("t5.new_cs0", 32'(bus.checksum), 32'd0);
    @(posedge clock); #1;
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    wait_done("t5");
    check("t5.new_writes", 32'(wq_addr.size()), 32'd1);
    if (wq_addr.size() == 1) begin
      check("t5.new_addr", 32'(wq_addr[0]), 32'd0);
      check("t5.new_data", wq_data[0], 32'h1234_5678);
    end
    check("t5.new_checksum", 32'(bus.checksum), 32'h0114);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
